// File: rtl/mips_ctrl_decoder_if.sv
// Bundle between the MIPS main control decoder and the stage that consumes its
// strobes. The master drives opcode/en/flush and receives the registered control
// word. The slave is the decoder itself.
// The optional illegal_op strobe is present only when CTRL_ILLEGAL_OP_EN is defined.
interface mips_ctrl_decoder_if #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 2
);
    logic              en;
    logic              flush;
    logic [OPW-1:0]    opcode;
    logic              RsWrite;
    logic              ALUSrc;
    logic              MemtoReg;
    logic              WrReg1;
    logic              WrReg2;
    logic              MemRead;
    logic              MemWr;
    logic              BranchE;
    logic              BranchNE;
    logic              J;
    logic              Jal;
    logic              ORI;
    logic              LUI;
    logic [ALUOPW-1:0] ALUop;
`ifdef CTRL_ILLEGAL_OP_EN
    logic              illegal_op;

    modport master (
        output en, flush, opcode,
        input  RsWrite, ALUSrc, MemtoReg, WrReg1, WrReg2, MemRead, MemWr,
               BranchE, BranchNE, J, Jal, ORI, LUI, ALUop, illegal_op
    );
    modport slave (
        input  en, flush, opcode,
        output RsWrite, ALUSrc, MemtoReg, WrReg1, WrReg2, MemRead, MemWr,
               BranchE, BranchNE, J, Jal, ORI, LUI, ALUop, illegal_op
    );
`else
    modport master (
        output en, flush, opcode,
        input  RsWrite, ALUSrc, MemtoReg, WrReg1, WrReg2, MemRead, MemWr,
               BranchE, BranchNE, J, Jal, ORI, LUI, ALUop
    );
    modport slave (
        input  en, flush, opcode,
        output RsWrite, ALUSrc, MemtoReg, WrReg1, WrReg2, MemRead, MemWr,
               BranchE, BranchNE, J, Jal, ORI, LUI, ALUop
    );
`endif
endinterface

// File: rtl/mips_ctrl_decoder.sv
// Main control decoder for the single-issue 32-bit MIPS datapath.
// It turns the 6-bit opcode into registered control strobes with one cycle of latency.
// Reset, flush and unknown opcodes all produce the all-zero NOP word.
// flush has priority over en, and en = 0 holds the current word.
// Optional feature macro: CTRL_ILLEGAL_OP_EN. It adds the registered illegal_op
// flag for opcodes that are not in the decode table.
module mips_ctrl_decoder #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_ctrl_decoder_if.slave   bus
);
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_JAL   = 6'b000011;

    localparam logic [ALUOPW-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOPW-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOPW-1:0] ALU_FUNCT = 2'b10;
    localparam logic [ALUOPW-1:0] ALU_OR    = 2'b11;

    typedef struct packed {
        logic              rs_write;
        logic              alu_src;
        logic              mem_to_reg;
        logic              wr_reg1;
        logic              wr_reg2;
        logic              mem_read;
        logic              mem_wr;
        logic              branch_e;
        logic              branch_ne;
        logic              j;
        logic              jal;
        logic              ori;
        logic              lui;
        logic [ALUOPW-1:0] alu_op;
    } ctrl_t;

    ctrl_t dec;
    logic  known;
    ctrl_t ctrl_d, ctrl_q;

    // Opcode decode. An X/Z opcode matches no table entry, so it falls to the NOP default.
    always_comb begin
        dec   = '0;
        known = 1'b1;
        case (bus.opcode)
            OP_RTYPE: begin
                dec.rs_write = 1'b1;
                dec.wr_reg1  = 1'b1;
                dec.alu_op   = ALU_FUNCT;
            end
            OP_LW: begin
                dec.rs_write   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec.alu_src = 1'b1;
                dec.mem_wr  = 1'b1;
                dec.alu_op  = ALU_ADD;
            end
            OP_BEQ: begin
                dec.branch_e = 1'b1;
                dec.alu_op   = ALU_SUB;
            end
            OP_BNE: begin
                dec.branch_ne = 1'b1;
                dec.alu_op    = ALU_SUB;
            end
            OP_ORI: begin
                dec.rs_write = 1'b1;
                dec.alu_src  = 1'b1;
                dec.ori      = 1'b1;
                dec.alu_op   = ALU_OR;
            end
            OP_LUI: begin
                dec.rs_write = 1'b1;
                dec.alu_src  = 1'b1;
                dec.lui      = 1'b1;
                dec.alu_op   = ALU_ADD;
            end
            OP_J: begin
                dec.j = 1'b1;
            end
            OP_JAL: begin
                dec.j        = 1'b1;
                dec.jal      = 1'b1;
                dec.rs_write = 1'b1;
                dec.wr_reg2  = 1'b1;
            end
            default: begin
                dec   = '0;
                known = 1'b0;
            end
        endcase
    end

    // Next control word: flush inserts a bubble, en loads the decode, otherwise hold.
    always_comb begin
        ctrl_d = ctrl_q;
        if (bus.flush) begin
            ctrl_d = '0;
        end else if (bus.en) begin
            ctrl_d = dec;
        end
    end

    // Control word register, forced to NOP asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.RsWrite  = ctrl_q.rs_write;
    assign bus.ALUSrc   = ctrl_q.alu_src;
    assign bus.MemtoReg = ctrl_q.mem_to_reg;
    assign bus.WrReg1   = ctrl_q.wr_reg1;
    assign bus.WrReg2   = ctrl_q.wr_reg2;
    assign bus.MemRead  = ctrl_q.mem_read;
    assign bus.MemWr    = ctrl_q.mem_wr;
    assign bus.BranchE  = ctrl_q.branch_e;
    assign bus.BranchNE = ctrl_q.branch_ne;
    assign bus.J        = ctrl_q.j;
    assign bus.Jal      = ctrl_q.jal;
    assign bus.ORI      = ctrl_q.ori;
    assign bus.LUI      = ctrl_q.lui;
    assign bus.ALUop    = ctrl_q.alu_op;

`ifdef CTRL_ILLEGAL_OP_EN
    logic illegal_d, illegal_q;

    // Illegal-opcode flag follows the same flush/en/hold rules as the control word.
    always_comb begin
        illegal_d = illegal_q;
        if (bus.flush) begin
            illegal_d = 1'b0;
        end else if (bus.en) begin
            illegal_d = ~known;
        end
    end

    // Illegal-opcode flag register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegal_op = illegal_q;
`else
    // Without the illegal-opcode flag, unknown opcodes are simply NOPs.
    logic unused_known;
    assign unused_known = known;
`endif
endmodule

// File: tb/tb_mips_ctrl_decoder.sv
// Self-checking bench for mips_ctrl_decoder: directed steps plus a randomized run.
// The expectations come from a table-driven reference model.
// Define CTRL_ILLEGAL_OP_EN to also check illegal_op.
module tb_mips_ctrl_decoder;
    logic clk;
    logic rst_n;

    mips_ctrl_decoder_if #(.OPW(6), .ALUOPW(2)) ifc ();

    mips_ctrl_decoder #(.OPW(6), .ALUOPW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word layout: {RsWrite,ALUSrc,MemtoReg,WrReg1,WrReg2,MemRead,MemWr,
    //                        BranchE,BranchNE,J,Jal,ORI,LUI,ALUop[1:0]}
    localparam logic [14:0] M_RSW  = 15'h1 << 14;
    localparam logic [14:0] M_ASRC = 15'h1 << 13;
    localparam logic [14:0] M_M2R  = 15'h1 << 12;
    localparam logic [14:0] M_WR1  = 15'h1 << 11;
    localparam logic [14:0] M_WR2  = 15'h1 << 10;
    localparam logic [14:0] M_MRD  = 15'h1 << 9;
    localparam logic [14:0] M_MWR  = 15'h1 << 8;
    localparam logic [14:0] M_BEQ  = 15'h1 << 7;
    localparam logic [14:0] M_BNE  = 15'h1 << 6;
    localparam logic [14:0] M_J    = 15'h1 << 5;
    localparam logic [14:0] M_JAL  = 15'h1 << 4;
    localparam logic [14:0] M_ORI  = 15'h1 << 3;
    localparam logic [14:0] M_LUI  = 15'h1 << 2;

    logic [14:0] exp_tbl [bit [5:0]];
    logic [5:0]  known_ops [9];
    logic [14:0] model_word;
    logic        model_ill;
    int          n_cmp;
    int          n_err;

    function automatic logic [14:0] observed();
        return {ifc.RsWrite, ifc.ALUSrc, ifc.MemtoReg, ifc.WrReg1, ifc.WrReg2,
                ifc.MemRead, ifc.MemWr, ifc.BranchE, ifc.BranchNE, ifc.J, ifc.Jal,
                ifc.ORI, ifc.LUI, ifc.ALUop};
    endfunction

    function automatic logic [14:0] lookup(input logic [5:0] op);
        if (exp_tbl.exists(op)) return exp_tbl[op];
        return 15'h0;
    endfunction

    task automatic check(input string tag);
        logic [14:0] obs;
        obs = observed();
        n_cmp++;
        assert (obs === model_word) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, model_word);
        end
`ifdef CTRL_ILLEGAL_OP_EN
        n_cmp++;
        assert (ifc.illegal_op === model_ill) else begin
            n_err++;
            $error("FAIL %s.illegal_op: observed=%b expected=%b", tag, ifc.illegal_op, model_ill);
        end
`endif
    endtask

    task automatic check_invariants(input string tag);
        logic ok;
        ok = !(ifc.MemRead && ifc.MemWr)
          && ((int'(ifc.BranchE) + int'(ifc.BranchNE) + int'(ifc.J)) <= 1)
          && !(ifc.WrReg1 && ifc.WrReg2)
          && (!ifc.Jal || ifc.J);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s.invariants: observed=%b expected=1 word=%b", tag, ok, observed());
        end
    endtask

    // One clock: drive inputs away from the edge, advance the model at the edge,
    // then check just after it.
    task automatic step(input logic en, input logic flush, input logic [5:0] op,
                        input string tag);
        @(negedge clk);
        ifc.en     = en;
        ifc.flush  = flush;
        ifc.opcode = op;
        @(posedge clk);
        if (flush) begin
            model_word = '0;
            model_ill  = 1'b0;
        end else if (en) begin
            model_word = lookup(op);
            model_ill  = !exp_tbl.exists(op);
        end
        #1;
        check(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_tbl[6'b000000] = M_RSW | M_WR1 | 15'b10;
        exp_tbl[6'b100011] = M_RSW | M_ASRC | M_M2R | M_MRD | 15'b00;
        exp_tbl[6'b101011] = M_ASRC | M_MWR | 15'b00;
        exp_tbl[6'b000100] = M_BEQ | 15'b01;
        exp_tbl[6'b000101] = M_BNE | 15'b01;
        exp_tbl[6'b001101] = M_RSW | M_ASRC | M_ORI | 15'b11;
        exp_tbl[6'b001111] = M_RSW | M_ASRC | M_LUI | 15'b00;
        exp_tbl[6'b000010] = M_J;
        exp_tbl[6'b000011] = M_J | M_JAL | M_RSW | M_WR2;
        known_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b001101, 6'b001111, 6'b000010, 6'b000011};

        // Power-up reset
        ifc.en = 1'b0; ifc.flush = 1'b0; ifc.opcode = 6'b000000;
        rst_n = 1'b1;
        model_word = '0;
        model_ill  = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 6'b100011, "idle_after_reset");

        // Full decode table, one opcode per cycle
        foreach (known_ops[i]) step(1'b1, 1'b0, known_ops[i], $sformatf("table_%b", known_ops[i]));

        // Asynchronous reset mid-cycle after an lw decode
        step(1'b1, 1'b0, 6'b100011, "lw_before_reset");
        #2 rst_n = 1'b0;
        model_word = '0;
        model_ill  = 1'b0;
        #1 check("async_reset_midcycle");
        @(negedge clk);
        rst_n = 1'b1;

        // Stall holds a sw decode
        step(1'b1, 1'b0, 6'b101011, "stall_load_sw");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b000000, $sformatf("stall_hold_%0d", i));

        // Flush beats enable
        step(1'b1, 1'b0, 6'b000011, "pre_flush_jal");
        step(1'b1, 1'b1, 6'b100011, "flush_priority");
        step(1'b0, 1'b1, 6'b000000, "flush_while_stalled");

        // Unknown opcode, then a known one clears the illegal flag
        step(1'b1, 1'b0, 6'b111111, "unknown_111111");
        step(1'b1, 1'b0, 6'b000000, "after_unknown_rtype");
        step(1'b1, 1'b0, 6'b010000, "unknown_010000");
        step(1'b0, 1'b0, 6'b000000, "unknown_held");
        step(1'b0, 1'b1, 6'b000000, "unknown_flushed");

        // Randomized run with invariant checks every cycle
        for (int i = 0; i < 1000; i++) begin
            logic [5:0] op;
            logic       en;
            logic       fl;
            if ($urandom_range(1, 0) == 1) op = known_ops[$urandom_range(8, 0)];
            else                           op = 6'($urandom);
            en = ($urandom_range(3, 0) != 0);
            fl = ($urandom_range(15, 0) == 0);
            step(en, fl, op, $sformatf("rand_%0d_op%b", i, op));
            check_invariants($sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
